// File: rtl/cla_byte_serial_adder.sv
// Byte-serial W-bit adder: one byte slice per cycle through an 8-bit carry-lookahead generator.
// Latency NBYTES cycles from accept to done; start is ignored while busy and results hold until the next accept.

module cla8_carry_gen (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin,
    output logic [7:0] c
);
    logic [7:0] g;
    logic [7:0] p;

    assign g = a & b;
    assign p = a ^ b;

    // Flat lookahead: c[i] = g[i] | p[i]g[i-1] | ... | p[i..0]cin, no ripple chain.
    always_comb begin
        logic acc;
        logic prod;
        c = '0;
        for (int i = 0; i < 8; i++) begin
            acc  = g[i];
            prod = p[i];
            for (int j = i - 1; j >= 0; j--) begin
                acc  = acc | (prod & g[j]);
                prod = prod & p[j];
            end
            c[i] = acc | (prod & cin);
        end
    end
endmodule

module cla_byte_serial_adder #(
    parameter int NBYTES = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [8*NBYTES-1:0] a,
    input  logic [8*NBYTES-1:0] b,
    input  logic                cin,
    output logic                busy,
    output logic                done,
    output logic [8*NBYTES-1:0] sum,
    output logic                cout,
    output logic                overflow
);
    localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]              state;
    logic [IW-1:0]           idx;
    logic                    carry_reg;
    logic [NBYTES-1:0][7:0]  a_reg;
    logic [NBYTES-1:0][7:0]  b_reg;
    logic [NBYTES-1:0][7:0]  sum_reg;
    logic                    cout_reg;
    logic                    ovf_reg;

    logic [7:0] ab;
    logic [7:0] bb;
    logic [7:0] c;
    logic [7:0] sum_byte;
    logic       last;

    assign ab       = a_reg[idx];
    assign bb       = b_reg[idx];
    assign last     = (idx == IW'(NBYTES - 1));
    assign sum_byte = (ab ^ bb) ^ {c[6:0], carry_reg};

    cla8_carry_gen u_gen (
        .a   (ab),
        .b   (bb),
        .cin (carry_reg),
        .c   (c)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            idx       <= '0;
            carry_reg <= 1'b0;
            a_reg     <= '0;
            b_reg     <= '0;
            sum_reg   <= '0;
            cout_reg  <= 1'b0;
            ovf_reg   <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        a_reg     <= a;
                        b_reg     <= b;
                        carry_reg <= cin;
                        idx       <= '0;
                        state     <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    sum_reg[idx] <= sum_byte;
                    carry_reg    <= c[7];
                    if (last) begin
                        cout_reg <= c[7];
                        ovf_reg  <= c[7] ^ c[6];
                        idx      <= '0;
                        state    <= DONE;
                    end else begin
                        idx <= idx + IW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy     = (state == RUN);
    assign done     = (state == DONE);
    assign sum      = sum_reg;
    assign cout     = cout_reg;
    assign overflow = ovf_reg;
endmodule

// File: tb/tb_cla_byte_serial_adder.sv
// Directed and swept checks for the byte-serial CLA adder at NBYTES = 4 and NBYTES = 1.
module tb_cla_byte_serial_adder;
    logic        clk;
    logic        rst;

    logic        start4;
    logic [31:0] a4, b4;
    logic        cin4;
    logic        busy4, done4, cout4, ovf4;
    logic [31:0] sum4;

    logic        start1;
    logic [7:0]  a1, b1;
    logic        cin1;
    logic        busy1, done1, cout1, ovf1;
    logic [7:0]  sum1;

    int n_cmp;
    int n_err;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
        logic [31:0] exp_sum;
        logic        exp_cout;
        logic        exp_ovf;
    } vec_t;

    vec_t vecs[7];

    cla_byte_serial_adder #(.NBYTES(4)) u_dut4 (
        .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4), .cin(cin4),
        .busy(busy4), .done(done4), .sum(sum4), .cout(cout4), .overflow(ovf4)
    );

    cla_byte_serial_adder #(.NBYTES(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .cin(cin1),
        .busy(busy1), .done(done1), .sum(sum1), .cout(cout1), .overflow(ovf1)
    );

    initial clk = 1'b0;
    always #30 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits for done on the 4-byte instance; returns cycles counted after the accept edge.
    task automatic wait_done4(output int cycles);
        cycles = 0;
        while (!done4 && cycles < 20) begin
            tick();
            cycles++;
        end
    endtask

    task automatic run_add4(input string name, input logic [31:0] av, input logic [31:0] bv,
                            input logic cv, input logic [31:0] es, input logic ec, input logic eo);
        int cyc;
        start4 = 1'b1; a4 = av; b4 = bv; cin4 = cv;
        tick();
        start4 = 1'b0;
        check({name, " busy_after_accept"}, 64'(busy4), 64'd1);
        wait_done4(cyc);
        check({name, " latency"}, 64'(cyc), 64'd4);
        check({name, " busy_in_done"}, 64'(busy4), 64'd0);
        check({name, " sum"}, 64'(sum4), 64'(es));
        check({name, " cout"}, 64'(cout4), 64'(ec));
        check({name, " overflow"}, 64'(ovf4), 64'(eo));
    endtask

    initial begin
        int cyc;
        logic done_seen;
        logic [8:0] full;
        logic       eo1;

        n_cmp = 0;
        n_err = 0;

        vecs[0] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b0};
        vecs[1] = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1};
        vecs[2] = '{32'h12345678, 32'h9ABCDEF0, 1'b1, 32'hACF13569, 1'b0, 1'b0};
        vecs[3] = '{32'h00000000, 32'h00000000, 1'b0, 32'h00000000, 1'b0, 1'b0};
        vecs[4] = '{32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1, 1'b1};
        vecs[5] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0};
        vecs[6] = '{32'h000000FF, 32'h00000001, 1'b0, 32'h00000100, 1'b0, 1'b0};

        rst = 1'b1;
        start4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0;
        start1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
        #1;
        check("reset busy", 64'(busy4), 64'd0);
        check("reset done", 64'(done4), 64'd0);
        check("reset sum", 64'(sum4), 64'd0);
        check("reset cout", 64'(cout4), 64'd0);
        check("reset overflow", 64'(ovf4), 64'd0);
        check("reset n1 busy/done/sum", {53'd0, busy1, done1, sum1, cout1, ovf1}, 64'd0);
        tick();
        tick();
        rst = 1'b0;
        tick();

        for (int i = 0; i < 7; i++) begin
            run_add4($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].cin,
                     vecs[i].exp_sum, vecs[i].exp_cout, vecs[i].exp_ovf);
            tick();
            check($sformatf("vec%0d done_pulse_width", i), 64'(done4), 64'd0);
        end

        // start pulsed mid-RUN with different operands must be ignored
        start4 = 1'b1; a4 = 32'h11111111; b4 = 32'h22222222; cin4 = 1'b0;
        tick();
        start4 = 1'b0;
        tick();
        start4 = 1'b1; a4 = 32'hDEADBEEF; b4 = 32'h01010101; cin4 = 1'b1;
        tick();
        start4 = 1'b0;
        wait_done4(cyc);
        check("ignore_start latency", 64'(cyc), 64'd2);
        check("ignore_start sum", 64'(sum4), 64'h33333333);
        check("ignore_start cout", 64'(cout4), 64'd0);

        // start held through the done cycle: accepted without an IDLE gap
        start4 = 1'b1; a4 = 32'd1; b4 = 32'd2; cin4 = 1'b0;
        tick();
        start4 = 1'b0;
        check("b2b busy", 64'(busy4), 64'd1);
        check("b2b done_low", 64'(done4), 64'd0);
        wait_done4(cyc);
        check("b2b latency", 64'(cyc), 64'd4);
        check("b2b sum", 64'(sum4), 64'd3);
        tick();

        // reset after slice 1 is written
        start4 = 1'b1; a4 = 32'h12345678; b4 = 32'h11111111; cin4 = 1'b0;
        tick();
        start4 = 1'b0;
        tick();
        tick();
        check("midrun partial sum", 64'(sum4[15:0]), 64'h6789);
        rst = 1'b1;
        #1;
        check("midrun_rst busy", 64'(busy4), 64'd0);
        check("midrun_rst sum", 64'(sum4), 64'd0);
        check("midrun_rst done", 64'(done4), 64'd0);
        tick();
        rst = 1'b0;
        done_seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (done4) done_seen = 1'b1;
        end
        check("midrun_rst no_done", 64'(done_seen), 64'd0);
        run_add4("post_rst", 32'h000000FF, 32'h00000001, 1'b0, 32'h00000100, 1'b0, 1'b0);
        tick();

        // NBYTES = 1 random sweep
        for (int i = 0; i < 1000; i++) begin
            a1 = 8'($urandom);
            b1 = 8'($urandom);
            cin1 = 1'($urandom);
            full = {1'b0, a1} + {1'b0, b1} + {8'd0, cin1};
            eo1 = (a1[7] == b1[7]) && (full[7] != a1[7]);
            start1 = 1'b1;
            tick();
            start1 = 1'b0;
            check($sformatf("n1 vec%0d busy", i), 64'(busy1), 64'd1);
            tick();
            check($sformatf("n1 vec%0d done", i), 64'(done1), 64'd1);
            check($sformatf("n1 vec%0d cout_sum", i), 64'({cout1, sum1}), 64'(full));
            check($sformatf("n1 vec%0d overflow", i), 64'(ovf1), 64'(eo1));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
